// File: rtl/seg7_reader.sv
// Seven-segment bus reader: debounces an active-low segment pattern over STABLE_CNT
// strobed samples, decodes it and hands the digit to a consumer with Valid/Ack.
// Optional macro SEG7_READER_HEX_EN adds decoding of the hex glyphs A..F.
//
// state | meaning
// IDLE  | no candidate pattern yet
// TRACK | counting consecutive samples of the candidate
// LOCK  | candidate accepted, waiting for the bus to change
module seg7_reader #(
    parameter int STABLE_CNT = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [6:0] Seg,
    input  logic       Sample,
    input  logic       Ack,
    output logic [3:0] Value,
    output logic       Valid,
    output logic       Bad,
    output logic       Overrun
);

    typedef enum logic [1:0] {IDLE, TRACK, LOCK} state_t;

    localparam logic [3:0] LP_STABLE = 4'(STABLE_CNT);
    localparam logic [6:0] LP_BLANK  = 7'h7F;

    state_t     r_state;
    logic [6:0] r_cand;
    logic [6:0] r_last;
    logic [3:0] r_cnt;
    logic [3:0] r_value;
    logic       r_valid;
    logic       r_bad;
    logic       r_overrun;

    logic       w_match;
    logic [3:0] w_cnt_inc;
    logic       w_accept;
    logic       w_report;
    logic [3:0] w_dec_val;
    logic       w_dec_bad;

    always_comb begin
        w_dec_val = 4'd0;
        w_dec_bad = 1'b0;
        case (Seg)
            7'h40: w_dec_val = 4'd0;
            7'h79: w_dec_val = 4'd1;
            7'h24: w_dec_val = 4'd2;
            7'h30: w_dec_val = 4'd3;
            7'h19: w_dec_val = 4'd4;
            7'h12: w_dec_val = 4'd5;
            7'h02: w_dec_val = 4'd6;
            7'h78: w_dec_val = 4'd7;
            7'h00: w_dec_val = 4'd8;
            7'h18: w_dec_val = 4'd9;
`ifdef SEG7_READER_HEX_EN
            7'h08: w_dec_val = 4'd10;
            7'h03: w_dec_val = 4'd11;
            7'h46: w_dec_val = 4'd12;
            7'h21: w_dec_val = 4'd13;
            7'h06: w_dec_val = 4'd14;
            7'h0E: w_dec_val = 4'd15;
`endif
            default: w_dec_bad = 1'b1;
        endcase
    end

    // Accept fires on the sample that brings the run length up to STABLE_CNT,
    // including a fresh load when STABLE_CNT is 1.
    always_comb begin
        w_match   = (Seg == r_cand);
        w_cnt_inc = (r_cnt >= LP_STABLE) ? LP_STABLE : r_cnt + 4'd1;
        w_accept  = 1'b0;
        if (Sample) begin
            case (r_state)
                IDLE:    w_accept = (LP_STABLE == 4'd1);
                TRACK:   w_accept = w_match ? (w_cnt_inc == LP_STABLE) : (LP_STABLE == 4'd1);
                LOCK:    w_accept = !w_match && (LP_STABLE == 4'd1);
                default: w_accept = 1'b0;
            endcase
        end
        w_report = w_accept && (Seg != r_last) && (Seg != LP_BLANK);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_cand    <= LP_BLANK;
            r_last    <= LP_BLANK;
            r_cnt     <= 4'd0;
            r_value   <= 4'd0;
            r_valid   <= 1'b0;
            r_bad     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (Sample) begin
                case (r_state)
                    IDLE: begin
                        r_cand  <= Seg;
                        r_cnt   <= 4'd1;
                        r_state <= (LP_STABLE == 4'd1) ? LOCK : TRACK;
                    end
                    TRACK: begin
                        if (w_match) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == LP_STABLE)
                                r_state <= LOCK;
                        end else begin
                            r_cand  <= Seg;
                            r_cnt   <= 4'd1;
                            r_state <= (LP_STABLE == 4'd1) ? LOCK : TRACK;
                        end
                    end
                    LOCK: begin
                        if (!w_match) begin
                            r_cand  <= Seg;
                            r_cnt   <= 4'd1;
                            r_state <= (LP_STABLE == 4'd1) ? LOCK : TRACK;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end

            if (w_accept)
                r_last <= Seg;

            // A coincident Ack consumes the old result, so only an unacked one overruns.
            if (w_report) begin
                r_value <= w_dec_val;
                r_bad   <= w_dec_bad;
                r_valid <= 1'b1;
                if (r_valid && !Ack)
                    r_overrun <= 1'b1;
            end else if (Ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign Value   = r_value;
    assign Valid   = r_valid;
    assign Bad     = r_bad;
    assign Overrun = r_overrun;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: expected reports are queued as stimulus is driven
// and popped when the reader presents a result.
module tb_seg7_reader;

    logic       Clock;
    logic       Reset;
    logic [6:0] Seg;
    logic       Sample;
    logic       Ack;
    logic [3:0] Value;
    logic       Valid;
    logic       Bad;
    logic       Overrun;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    logic prev_valid = 1'b0;
    logic [4:0] q[$];
    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

    seg7_reader #(.STABLE_CNT(4)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Seg     (Seg),
        .Sample  (Sample),
        .Ack     (Ack),
        .Value   (Value),
        .Valid   (Valid),
        .Bad     (Bad),
        .Overrun (Overrun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (Valid && !prev_valid)
            rises++;
        prev_valid = Valid;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic smp(input logic [6:0] s, input logic a);
        Seg    = s;
        Sample = 1'b1;
        Ack    = a;
        @(posedge Clock);
        #1;
        Sample = 1'b0;
        Ack    = 1'b0;
    endtask

    task automatic hold(input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++)
            smp(s, 1'b0);
    endtask

    task automatic ack();
        Ack = 1'b1;
        @(posedge Clock);
        #1;
        Ack = 1'b0;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        q.delete();
    endtask

    task automatic push(input logic [3:0] v, input logic b);
        q.push_back({b, v});
    endtask

    task automatic expect_report(input string tag);
        logic [4:0] e;
        chk({tag, "_pending"}, 8'(q.size() > 0), 8'd1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_valid"}, 8'(Valid), 8'd1);
            chk({tag, "_value"}, 8'(Value), 8'(e[3:0]));
            chk({tag, "_bad"},   8'(Bad),   8'(e[4]));
        end
    endtask

    initial begin
        int r0;
        Reset  = 1'b1;
        Seg    = 7'h7F;
        Sample = 1'b0;
        Ack    = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_value",   8'(Value),   8'd0);
        chk("rst_valid",   8'(Valid),   8'd0);
        chk("rst_bad",     8'(Bad),     8'd0);
        chk("rst_overrun", 8'(Overrun), 8'd0);
        Reset = 1'b0;

        // Ack with nothing pending has no effect
        ack();
        chk("idle_ack_valid", 8'(Valid), 8'd0);

        // 3 held for four samples
        hold(7'h30, 3);
        chk("three_early", 8'(Valid), 8'd0);
        push(4'd3, 1'b0);
        smp(7'h30, 1'b0);
        expect_report("three");
        ack();
        chk("three_acked", 8'(Valid), 8'd0);

        // interrupted run of 3 then a full run of 2
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            smp(7'h30, 1'b0);
            chk("run_no3", 8'(Valid), 8'd0);
        end
        for (int i = 0; i < 3; i++) begin
            smp(7'h24, 1'b0);
            chk("run_no2_early", 8'(Valid), 8'd0);
        end
        push(4'd2, 1'b0);
        smp(7'h24, 1'b0);
        expect_report("two");
        ack();

        // repeat suppression and blank
        pulse_reset();
        r0 = rises;
        push(4'd2, 1'b0);
        hold(7'h24, 4);
        expect_report("rep_first");
        ack();
        hold(7'h24, 10);
        chk("rep_held", 8'(Valid), 8'd0);
        hold(7'h7F, 4);
        chk("rep_blank", 8'(Valid), 8'd0);
        push(4'd2, 1'b0);
        hold(7'h24, 4);
        expect_report("rep_second");
        ack();
        repeat (2) @(posedge Clock);
        #1;
        chk("rep_count", 8'(rises - r0), 8'd2);

        // overwrite without Ack
        pulse_reset();
        push(4'd1, 1'b0);
        hold(7'h79, 4);
        expect_report("ovr_one");
        push(4'd5, 1'b0);
        hold(7'h12, 4);
        expect_report("ovr_five");
        chk("ovr_flag", 8'(Overrun), 8'd1);
        ack();
        chk("ovr_sticky", 8'(Overrun), 8'd1);

        // new report coincides with Ack
        pulse_reset();
        chk("ovr_cleared", 8'(Overrun), 8'd0);
        push(4'd1, 1'b0);
        hold(7'h79, 4);
        expect_report("coin_one");
        hold(7'h12, 3);
        push(4'd5, 1'b0);
        smp(7'h12, 1'b1);
        expect_report("coin_five");
        chk("coin_overrun", 8'(Overrun), 8'd0);
        ack();
        chk("coin_acked", 8'(Valid), 8'd0);

        // illegal and hex glyphs
        pulse_reset();
        hold(7'h7F, 4);
        chk("blank_first", 8'(Valid), 8'd0);
`ifdef SEG7_READER_HEX_EN
        push(4'd10, 1'b0);
`else
        push(4'd0, 1'b1);
`endif
        hold(7'h08, 4);
        expect_report("hex_a");
        ack();
        push(4'd0, 1'b1);
        hold(7'h55, 4);
        expect_report("illegal");
        ack();

        // all decimal glyphs
        pulse_reset();
        for (int d = 0; d < 10; d++) begin
            push(4'(d), 1'b0);
            hold(glyph[d], 4);
            expect_report("digit");
            ack();
        end

        // reset mid-track
        pulse_reset();
        hold(7'h40, 3);
        Reset = 1'b1;
        #1;
        chk("mid_value",   8'(Value),   8'd0);
        chk("mid_valid",   8'(Valid),   8'd0);
        chk("mid_bad",     8'(Bad),     8'd0);
        chk("mid_overrun", 8'(Overrun), 8'd0);
        Reset = 1'b0;
        smp(7'h40, 1'b0);
        chk("mid_no_report", 8'(Valid), 8'd0);

        // reset with a result pending
        pulse_reset();
        push(4'd4, 1'b0);
        hold(7'h19, 4);
        expect_report("pend_four");
        pulse_reset();
        chk("pend_dropped", 8'(Valid), 8'd0);
        hold(7'h19, 3);
        chk("pend_restart", 8'(Valid), 8'd0);
        push(4'd4, 1'b0);
        smp(7'h19, 1'b0);
        expect_report("pend_again");
        ack();

        chk("queue_empty", 8'(q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, meaning the number of consecutive identical samples required to accept a pattern (legal range 1..15).
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Seg, input, 7 bits: active-low segment bus; bit0 = a through bit6 = g.
REQ-005 SHALL have port Sample, input, 1 bit: sample strobe, evaluated every Clock edge on which it is 1.
REQ-006 SHALL have port Ack, input, 1 bit: consumer acknowledge for Valid.
REQ-007 SHALL have port Value, output, 4 bits: decoded digit.
REQ-008 SHALL have port Valid, output, 1 bit: Value/Bad hold a new, unconsumed result.
REQ-009 SHALL have port Bad, output, 1 bit: the reported pattern is not a legal glyph; qualified by Valid.
REQ-010 SHALL have port Overrun, output, 1 bit: sticky flag, set when a result is overwritten before being acknowledged.

Function
REQ-011 SHALL decode legal patterns (hex Seg, active-low) as: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18.
REQ-012 SHALL treat every other non-blank pattern as illegal; it reports Bad=1 and Value=0.
REQ-013 SHALL implement FSM states IDLE (no candidate), TRACK (counting a candidate) and LOCK (candidate accepted, waiting for change).
REQ-014 SHALL, in IDLE on Sample, load Seg as candidate with cnt=1 and go to TRACK, or accept immediately if STABLE_CNT=1.
REQ-015 SHALL, in TRACK on Sample with Seg equal to candidate, increment cnt; when cnt reaches STABLE_CNT, it accepts and goes to LOCK.
REQ-016 SHALL, in TRACK on Sample with Seg different from candidate, reload candidate=Seg with cnt=1, staying in TRACK.
REQ-017 SHALL, in LOCK on Sample with Seg different from the accepted pattern, reload candidate=Seg with cnt=1 and go to TRACK; an equal Seg is ignored.
REQ-018 SHALL make no state change on cycles with Sample=0.
REQ-019 SHALL report on accept only when the pattern differs from the last accepted pattern; a repeated pattern produces no report.
REQ-020 SHALL, on accept of blank (7F), update the last accepted pattern without producing a report.
REQ-021 SHALL register reports: Value, Bad and Valid=1 appear the cycle after the accepting Sample edge.
REQ-022 SHALL hold Valid at 1 until a cycle with Ack=1, then clear it on that edge.
REQ-023 SHALL ignore Ack while Valid=0.
REQ-024 SHALL, when a new report coincides with Ack, load the new result and keep Valid=1, with no overrun.
REQ-025 SHALL, when a new report arrives with Valid=1 and Ack=0, overwrite Value/Bad, keep Valid=1 and set Overrun=1.
REQ-026 SHALL clear Overrun only on Reset.
REQ-027 SHALL saturate cnt at STABLE_CNT and never wrap.

Reset
REQ-028 SHALL, on Reset asserted, immediately set the state to IDLE, cnt=0, last accepted pattern=7F, Value=0, Valid=0, Bad=0 and Overrun=0.
REQ-029 SHALL, on Reset asserted mid-TRACK or while Valid is pending, discard the candidate and the pending result; no report follows deassertion.

Configuration
REQ-030 SHALL support macro SEG7_READER_HEX_EN.
REQ-031 SHALL, when SEG7_READER_HEX_EN is defined, additionally decode A=08, b=03, C=46, d=21, E=06, F=0E as legal values 10..15.
REQ-032 SHALL, when SEG7_READER_HEX_EN is undefined, report those six patterns as Bad=1, Value=0.

Verification
REQ-033 SHALL cover: STABLE_CNT=4; Seg=30 held for 4 Sample cycles -> Valid=1, Value=3, Bad=0 on the cycle after the 4th; hold Ack -> Valid=0.
REQ-034 SHALL cover: samples 30,30,30,24,24,24,24 -> exactly one report, Value=2; no report for 3.
REQ-035 SHALL cover: 24 accepted; then 24 sampled 10 more cycles, then blank accepted, then 24 again -> exactly two reports of 2 in total, none for blank.
REQ-036 SHALL cover: 79 accepted, no Ack, then 12 accepted -> Value=5, Valid=1, Overrun=1; repeat with Ack on the reporting cycle -> Overrun stays 0.
REQ-037 SHALL cover: 08 accepted -> Bad=1, Value=0 without the macro; Bad=0, Value=10 with SEG7_READER_HEX_EN.
REQ-038 SHALL cover: Reset pulsed after 3 matching samples of 40 -> outputs all 0 immediately; one more 40 sample -> no report.
